// File: rtl/seg_rx_pkg.sv
// Shared types and default sizing for the serial segment-display receiver.
package seg_rx_pkg;

    localparam int SEG_RX_WIDTH       = 64;
    localparam int SEG_RX_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } seg_rx_state_e;

endpackage

// File: rtl/seg_shift_rx_sync_edge.sv
// N-stage level synchronizer with a rising-edge detect against one extra
// registered copy of the synchronized level.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/seg_shift_rx.sv
// Serial-to-parallel display frame receiver (sclk/sdata/pen/clrn) in the clk domain.
// Bit-count checking is built only when SEG_SHIFT_RX_CNT_CHK_EN is defined.
module seg_shift_rx
    import seg_rx_pkg::*;
#(
    parameter int WIDTH       = SEG_RX_WIDTH,
    parameter int SYNC_STAGES = SEG_RX_SYNC_STAGES
) (
    input  logic                          clk,
    input  logic                          RSTN,
    input  logic                          sclk,
    input  logic                          sdata,
    input  logic                          pen,
    input  logic                          clrn,
    output logic [WIDTH-1:0]              dout,
    output logic                          frame_valid,
    output logic                          frame_err,
    output logic [$clog2(WIDTH+2)-1:0]    bit_cnt
);

    logic sclk_s, sclk_rise;
    logic sdata_s, sdata_rise;
    logic pen_s, pen_rise;
    logic clrn_s, clrn_rise;
    logic unused_sync;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst_n(RSTN), .d(sclk), .q(sclk_s), .rise(sclk_rise)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdata (
        .clk(clk), .rst_n(RSTN), .d(sdata), .q(sdata_s), .rise(sdata_rise)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_pen (
        .clk(clk), .rst_n(RSTN), .d(pen), .q(pen_s), .rise(pen_rise)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clrn (
        .clk(clk), .rst_n(RSTN), .d(clrn), .q(clrn_s), .rise(clrn_rise)
    );

    assign unused_sync = ^{sclk_s, sdata_rise, pen_s, clrn_rise};

    seg_rx_state_e    state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             frame_valid_q, frame_valid_d;
    logic             latch_en;

    assign latch_en = clrn_s && (state_q == LATCH);

    // A shift is applied even in the LATCH cycle; the latch copies the
    // register as it stood before that cycle's shift.
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        dout_d        = dout_q;
        frame_valid_d = 1'b0;
        if (!clrn_s) begin
            state_d = IDLE;
            shreg_d = '0;
            dout_d  = '0;
        end else begin
            if (sclk_rise) begin
                shreg_d = {shreg_q[WIDTH-2:0], sdata_s};
            end
            case (state_q)
                IDLE: begin
                    if (pen_rise) begin
                        state_d = LATCH;
                    end else if (sclk_rise) begin
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (pen_rise) begin
                        state_d = LATCH;
                    end
                end
                LATCH: begin
                    state_d       = IDLE;
                    dout_d        = shreg_q;
                    frame_valid_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            dout_q        <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            dout_q        <= dout_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign dout        = dout_q;
    assign frame_valid = frame_valid_q;

`ifdef SEG_SHIFT_RX_CNT_CHK_EN
    localparam int               CNT_W    = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // A bit shifted during the LATCH cycle belongs to the next frame.
    always_comb begin
        cnt_d = cnt_q;
        err_d = 1'b0;
        if (!clrn_s) begin
            cnt_d = '0;
        end else begin
            if (latch_en) begin
                err_d = (cnt_q != CNT_FULL);
                cnt_d = '0;
            end
            if (sclk_rise) begin
                cnt_d = sat_inc(cnt_d);
            end
        end
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bit_cnt   = cnt_q;
    assign frame_err = err_q;
`else
    assign bit_cnt   = '0;
    assign frame_err = 1'b0;
`endif

endmodule

// File: doc/seg_shift_rx.md
SEG_SHIFT_RX -- requirements
Module: seg_shift_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning the number of serial bits per display frame.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on each serial input (legal values 2..4).
REQ-003 SHALL have port clk, input, 1, the single system clock; all state is in this domain.
REQ-004 SHALL have port RSTN, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port sclk, input, 1, the serial shift clock from the transmitter (asynchronous to clk).
REQ-006 SHALL have port sdata, input, 1, the serial data bit, sampled on the sclk rising edge.
REQ-007 SHALL have port pen, input, 1, the latch enable; its rising edge transfers the frame to the output.
REQ-008 SHALL have port clrn, input, 1, the transmitter's active-low display clear.
REQ-009 SHALL have port dout, output, WIDTH, the latched parallel frame; bit WIDTH-1 holds the first bit shifted in.
REQ-010 SHALL have port frame_valid, output, 1, a one-clk pulse in the cycle dout updates.
REQ-011 SHALL have port frame_err, output, 1, asserted with frame_valid when the received bit count is not equal to WIDTH.
REQ-012 SHALL have port bit_cnt, output, $clog2(WIDTH+2), the number of bits received since the last latch or clear.

Function
REQ-013 SHALL pass sclk, sdata, pen and clrn through SYNC_STAGES flops each, then detect edges against one further registered copy.
REQ-014 SHALL run an FSM with states IDLE, SHIFT and LATCH.
REQ-015 SHALL, on each synchronized sclk rising edge, shift sdata into the LSB of the shift register, MSB-first (left shift).
REQ-016 SHALL take these FSM transitions:
- IDLE to SHIFT on an sclk edge.
- IDLE or SHIFT to LATCH on a pen edge.
- LATCH to IDLE unconditionally after one cycle.
REQ-017 SHALL, in LATCH, copy the shift register to dout, pulse frame_valid, clear bit_cnt, and keep the shift register contents.
REQ-018 SHALL make dout and frame_valid take effect exactly SYNC_STAGES+2 clk rising edges after pen rises at the pin, given input setup is met.
REQ-019 SHALL, when an sclk edge and a pen edge are detected in the same cycle, shift first; the latched frame then includes the new bit.
REQ-020 SHALL still perform the shift for an sclk edge that arrives during LATCH, and count it toward the next frame.
REQ-021 SHALL increment bit_cnt per shift and saturate it at WIDTH+1; shifting continues beyond WIDTH, with the oldest bits discarded.
REQ-022 SHALL, on a pen edge in IDLE with bit_cnt=0, still latch (re-latching the current shift register) and flag frame_err.
REQ-023 SHALL, while synchronized clrn is low, hold dout, the shift register and bit_cnt at 0, return the FSM to IDLE, and ignore sclk and pen edges.
REQ-024 SHALL require sclk high and low times of at least SYNC_STAGES+1 clk periods; faster input is out of specification.

Reset
REQ-025 SHALL, while RSTN is low, set all of the following regardless of clk:
- dout = 0, frame_valid = 0, frame_err = 0, bit_cnt = 0;
- shift register = 0, FSM = IDLE;
- synchronizer and edge flops = 0.
REQ-026 SHALL, on RSTN asserted mid-frame, discard the partial frame; the first edges after release are detected against 0 history.

Configuration
REQ-027 SHALL implement bit-count checking only when the macro SEG_SHIFT_RX_CNT_CHK_EN is defined.
REQ-028 SHALL, with SEG_SHIFT_RX_CNT_CHK_EN defined, behave as REQ-011, REQ-012, REQ-021 and REQ-022 describe.
REQ-029 SHALL, without SEG_SHIFT_RX_CNT_CHK_EN, remove the counter, tie frame_err and bit_cnt to 0, and leave all other behaviour unchanged.

Structure
REQ-030 SHALL place the FSM state typedef (IDLE/SHIFT/LATCH) and the default WIDTH/SYNC_STAGES constants in the shared package seg_rx_pkg.
REQ-031 SHALL use one sub-module, sync_edge, instantiated once per serial input: an N-stage synchronizer with rise output.

Verification
REQ-032 SHALL cover this scenario: shift 64 bits of 0xDEADBEEF_01234567 MSB-first with sclk period 8 clk, then pulse pen -> dout=0xDEADBEEF01234567, frame_valid is 1 for exactly one cycle, frame_err=0, and bit_cnt returns to 0.
REQ-033 SHALL cover this scenario: shift 63 bits then pulse pen -> frame_err=1 with frame_valid; shift 70 bits then pulse pen -> bit_cnt reads 65 before the latch and frame_err=1.
REQ-034 SHALL cover this scenario: sclk edge and pen edge synchronized in the same cycle as bit 64 -> the latched dout contains bit 64 and frame_err=0.
REQ-035 SHALL cover this scenario: drive clrn low for 5 clk after 32 bits -> dout=0 and bit_cnt=0; a following 64-bit frame latches correctly.
REQ-036 SHALL cover this scenario: assert RSTN low after 40 bits -> all outputs are 0 immediately (asynchronously); after release, a full frame latches with frame_err=0.
REQ-037 SHALL cover this scenario: build without SEG_SHIFT_RX_CNT_CHK_EN and run REQ-033 -> frame_err stays 0 and dout matches the last 64 bits shifted.
